// File: rtl/ysyx_22050612_pkg.sv
// Shared NPC constants: register-file geometry and write-back requester indices.
package ysyx_22050612_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_CSR = 2;

endpackage

// File: rtl/ysyx_22050612_rr_arbiter.sv
// Round-robin grant over N requesters; the search starts at ptr and wraps,
// and ptr moves just past the winner whenever the grant is accepted.
module ysyx_22050612_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] grant_idx;
  logic [N-1:0]     upper_mask;
  logic [N-1:0]     req_upper;
  logic [N-1:0]     pick_src;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign upper_mask[gi] = (PTR_W'(gi) >= ptr_reg);
    end
  endgenerate

  // Prefer requesters at or above ptr; fall back to the wrapped-around ones.
  assign req_upper = req & upper_mask;
  assign pick_src  = (|req_upper) ? req_upper : req;
  assign grant     = pick_src & (~pick_src + N'(1));

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
    ptr_next = ptr_reg;
    if (accept) begin
      ptr_next = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/ysyx_22050612_wb_arbiter.sv
// Write-back arbiter in front of the register file's single write port, with
// a per-register pending-write scoreboard for RAW hazard detection at issue.
module ysyx_22050612_wb_arbiter
  import ysyx_22050612_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = XLEN,
  parameter int NREQ       = WB_CSR + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic                       wen,
  output logic [ADDR_WIDTH-1:0]      waddr,
  output logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       alloc_valid,
  input  logic [ADDR_WIDTH-1:0]      alloc_addr,
  input  logic [ADDR_WIDTH-1:0]      rs1,
  input  logic [ADDR_WIDTH-1:0]      rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wen_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [NREGS-1:0]      busy_reg;
  logic [NREGS-1:0]      busy_next;

  ysyx_22050612_rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .accept (accept),
    .grant  (req_ready)
  );

  assign accept = |(req_valid & req_ready);

  // Grant is one-hot, so an AND-OR mux picks the winner's payload.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr = sel_addr | ({ADDR_WIDTH{req_ready[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      sel_data = sel_data | ({DATA_WIDTH{req_ready[i]}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // x0 writes still consume the grant but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_reg   <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      wen_reg <= accept && (sel_addr != '0);
      if (accept) begin
        waddr_reg <= sel_addr;
        wdata_reg <= sel_data;
      end
    end
  end

  assign wen   = wen_reg;
  assign waddr = waddr_reg;
  assign wdata = wdata_reg;

  // A new allocation beats a retiring write to the same register.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit       = alloc_valid && (alloc_addr == ADDR_WIDTH'(gi));
        assign clr_hit       = wen_reg && (waddr_reg == ADDR_WIDTH'(gi));
        assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign rs1_busy = (rs1 != '0) && busy_reg[rs1];
  assign rs2_busy = (rs2 != '0) && busy_reg[rs2];

endmodule

// File: tb/tb_ysyx_22050612_wb_arbiter.sv
// Directed bench for the write-back arbiter: arbitration order, output stage
// timing, x0 handling, scoreboard set/clear and asynchronous reset.
module tb_ysyx_22050612_wb_arbiter;
  import ysyx_22050612_pkg::*;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             alloc_valid;
  logic [AW-1:0]    alloc_addr;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic             rs1_busy;
  logic             rs2_busy;

  int checks = 0;
  int errors = 0;

  ysyx_22050612_wb_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NREQ       (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .wen         (wen),
    .waddr       (waddr),
    .wdata       (wdata),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_addr[i*AW +: AW]   = a;
    req_data[i*DW +: DW]   = d;
  endtask

  initial begin
    logic [NR-1:0] exp_grant;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    alloc_valid = 1'b0;
    alloc_addr  = '0;
    rs1         = '0;
    rs2         = '0;

    // Reset state
    step();
    step();
    check("rst_wen", 64'(wen), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", wdata, 64'd0);
    check("rst_ready_idle", 64'(req_ready), 64'd0);
    req_valid = 3'b110;
    #1;
    check("rst_ready_110", 64'(req_ready), 64'b010);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Round-robin with all three requesters continuously valid
    set_req(WB_ALU, 1'b1, 5'd1, 64'h100);
    set_req(WB_LSU, 1'b1, 5'd2, 64'h200);
    set_req(WB_CSR, 1'b1, 5'd3, 64'h300);
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_grant = NR'(1) << (k % 3);
      check($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(exp_grant));
      step();
      check($sformatf("rr_wen%0d", k), 64'(wen), 64'd1);
      check($sformatf("rr_waddr%0d", k), 64'(waddr), 64'((k % 3) + 1));
      check($sformatf("rr_wdata%0d", k), wdata, 64'(((k % 3) + 1) * 256));
    end
    req_valid = '0;

    // Single LSU write (ptr back at 0)
    set_req(WB_LSU, 1'b1, 5'd5, 64'hDEADBEEF);
    #1;
    check("single_ready", 64'(req_ready), 64'b010);
    step();
    req_valid = '0;
    check("single_wen", 64'(wen), 64'd1);
    check("single_waddr", 64'(waddr), 64'd5);
    check("single_wdata", wdata, 64'hDEADBEEF);
    step();
    check("single_wen_drop", 64'(wen), 64'd0);
    check("single_waddr_hold", 64'(waddr), 64'd5);
    check("single_wdata_hold", wdata, 64'hDEADBEEF);

    // x0 write from ALU (ptr=2, wraps to 0)
    set_req(WB_ALU, 1'b1, 5'd0, 64'h1234);
    #1;
    check("x0_ready", 64'(req_ready), 64'b001);
    step();
    req_valid = '0;
    check("x0_wen", 64'(wen), 64'd0);
    check("x0_waddr", 64'(waddr), 64'd0);
    check("x0_wdata", wdata, 64'h1234);
    req_valid = 3'b111;
    #1;
    check("x0_ptr_adv", 64'(req_ready), 64'b010);
    req_valid = '0;

    // Scoreboard life cycle on x7
    alloc_valid = 1'b1;
    alloc_addr  = 5'd7;
    rs1         = 5'd7;
    #1;
    check("sb_pre_alloc", 64'(rs1_busy), 64'd0);
    step();
    alloc_valid = 1'b0;
    check("sb_busy_set", 64'(rs1_busy), 64'd1);
    step();
    set_req(WB_ALU, 1'b1, 5'd7, 64'h77);
    #1;
    check("sb_alu_ready", 64'(req_ready), 64'b001);
    step();
    req_valid = '0;
    check("sb_wen", 64'(wen), 64'd1);
    check("sb_waddr", 64'(waddr), 64'd7);
    check("sb_busy_during_wb", 64'(rs1_busy), 64'd1);
    step();
    check("sb_wen_drop", 64'(wen), 64'd0);
    check("sb_busy_clear", 64'(rs1_busy), 64'd0);

    // Same-register set/clear collision, then different-register set/clear
    alloc_valid = 1'b1;
    alloc_addr  = 5'd7;
    set_req(WB_ALU, 1'b1, 5'd7, 64'h78);
    step();
    req_valid = '0;
    check("col_wen", 64'(wen), 64'd1);
    check("col_busy_a", 64'(rs1_busy), 64'd1);
    alloc_addr = 5'd7;
    set_req(WB_ALU, 1'b1, 5'd7, 64'h79);
    step();
    req_valid = '0;
    check("col_wen2", 64'(wen), 64'd1);
    check("col_set_wins", 64'(rs1_busy), 64'd1);
    alloc_addr = 5'd9;
    rs2        = 5'd9;
    step();
    alloc_valid = 1'b0;
    #1;
    check("diff_clear7", 64'(rs1_busy), 64'd0);
    check("diff_set9", 64'(rs2_busy), 64'd1);
    alloc_valid = 1'b1;
    alloc_addr  = 5'd0;
    step();
    alloc_valid = 1'b0;
    rs2 = 5'd0;
    #1;
    check("alloc_x0", 64'(rs2_busy), 64'd0);

    // Asynchronous reset in the middle of a write-back
    rs1 = 5'd9;
    set_req(WB_ALU, 1'b1, 5'd11, 64'hA1);
    set_req(WB_LSU, 1'b1, 5'd12, 64'hB2);
    set_req(WB_CSR, 1'b1, 5'd13, 64'hC3);
    step();
    req_valid = '0;
    check("mid_wen_before", 64'(wen), 64'd1);
    check("mid_busy_before", 64'(rs1_busy), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen", 64'(wen), 64'd0);
    check("mid_rst_waddr", 64'(waddr), 64'd0);
    check("mid_rst_wdata", wdata, 64'd0);
    check("mid_rst_busy", 64'(rs1_busy), 64'd0);
    req_valid = 3'b110;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'b010);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    req_valid = '0;
    check("post_rst_wen", 64'(wen), 64'd1);
    check("post_rst_waddr", 64'(waddr), 64'd12);
    check("post_rst_wdata", wdata, 64'hB2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_wb_arbiter.md
# ysyx_22050612_wb_arbiter

Write-back arbiter and pending-write scoreboard in front of the NPC integer register file's single write port. NREQ write-back sources (ALU, LSU load return, CSR) compete for the port. The block grants one source per cycle round-robin and drives the register file's write inputs from a registered output stage. A per-register busy scoreboard lets the issue stage detect RAW hazards on outstanding writes.

## Interface
- ADDR_WIDTH, 5: register index width; 2**ADDR_WIDTH registers.
- DATA_WIDTH, 64: register data width.
- NREQ, 3: number of write-back requesters, at least 2; index 0 is the ALU.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  requester i has a write pending.
- req_ready  out  NREQ  one-hot grant; a request is accepted when valid and ready are both high on an edge.
- req_addr  in  NREQ*ADDR_WIDTH  destination register; slice i belongs to requester i.
- req_data  in  NREQ*DATA_WIDTH  write data; slice i belongs to requester i.
- wen  out  1  register-file write enable, registered.
- waddr  out  ADDR_WIDTH  register-file write address, registered.
- wdata  out  DATA_WIDTH  register-file write data, registered.
- alloc_valid  in  1  issue stage marks a destination register as pending.
- alloc_addr  in  ADDR_WIDTH  register to mark pending.
- rs1, rs2  in  ADDR_WIDTH each  source registers to query.
- rs1_busy, rs2_busy  out  1 each  the queried register has an outstanding write; combinational.

## Operation
- **Round-robin arbitration.** Pointer `ptr` ranges over 0..NREQ-1.
  - Grant goes to the first requester with `req_valid` high, searching from `ptr` upward and wrapping.
  - `req_ready` is combinational, depends only on `req_valid` and `ptr`, and has at most one bit set.
  - At most one acceptance per cycle.
- **Pointer update.** On an acceptance by requester g, `ptr` becomes (g+1) mod NREQ. With no acceptance, `ptr` holds.
- **Output stage.** The output stage always drains, so there is no backpressure from the register file.
  - On an acceptance: wen <= (addr_g != 0), waddr <= addr_g, wdata <= data_g.
  - Otherwise wen <= 0; waddr and wdata hold their values.
- **Writes to x0.** A request with address 0 is accepted and consumes its grant, but never asserts `wen`.
- **Scoreboard.** One busy bit per register.
  - Set: `alloc_valid` with alloc_addr != 0.
  - Clear: on the edge where `wen` is high, for register `waddr`. This is the same edge on which the register file latches the data.
  - Set and clear of the same register on the same edge: set wins, and the bit stays 1 (a newer instruction targets it).
  - Set and clear of different registers on the same edge: both take effect.
- **Busy queries.** `rs*_busy` = busy[rs*]. A query of register 0 always returns 0.
- **Reset.** Asynchronous reset is required behaviour, including mid-operation, and takes effect with no clock edge. Reset values:
  - ptr=0.
  - wen=0, waddr=0, wdata=0.
  - All busy bits 0.
  - `req_ready` follows the arbitration rule with ptr=0.
  - Any write in the output stage is lost; requesters re-present after reset.

## Timing
- Request accepted on edge N gives `wen`/`waddr`/`wdata` valid during cycle N+1. The register file writes on edge N+1, and the busy bit clears on edge N+1.
- `alloc_valid` on edge N: `rs*_busy` reads 1 in cycle N+1.
- Throughput: one write per cycle sustained.
- Worst-case wait for a continuously valid requester: NREQ-1 cycles.
- No combinational path from `req_*` to `wen`/`waddr`/`wdata`.
- Combinational path `req_valid` -> `req_ready` is allowed. Requesters must not make `req_valid` depend on `req_ready`.

## Structure
- **Shared package** ysyx_22050612_pkg holds:
  - REG_ADDR_W=5 and XLEN=64.
  - Requester index constants: WB_ALU=0, WB_LSU=1, WB_CSR=2.
- **Sub-module** ysyx_22050612_rr_arbiter, parameterised by N. It contains the round-robin grant logic and the pointer register, with inputs req, accept and outputs grant.
- **Top level** contains the output register and the scoreboard.
- Estimated size: about 200 lines of RTL.

## Test plan
- **Reset:** drive rst_n=0 mid-cycle with wen=1 -> wen, waddr, wdata and all busy bits read 0 immediately; with req_valid=3'b110 after release, grant is 3'b010.
- **Round-robin:** req_valid=3'b111 held for 6 cycles, ptr=0 -> grants 001, 010, 100, 001, 010, 100; waddr follows each grantee's address one cycle later.
- **Single write:** LSU alone, addr=5, data=0xDEADBEEF -> accepted on edge N; during cycle N+1, wen=1, waddr=5, wdata=0xDEADBEEF; wen=0 in cycle N+2.
- **x0 write:** ALU, addr=0, data=0x1234 -> req_ready[0]=1 and the request is accepted; wen stays 0; ptr advances to 1.
- **Scoreboard life cycle:** alloc x7 on edge 1 -> rs1=7 gives rs1_busy=1 from cycle 2. ALU write to x7 accepted on edge 3 -> wen=1 in cycle 4; rs1_busy=0 from cycle 5.
- **Set/clear collision:** alloc x7 on the same edge that wen=1, waddr=7 commits -> busy[7] stays 1. Alloc x0 -> rs2=0 gives rs2_busy=0.
